// File: rtl/rst_seq.sv
// Reset sequencer: synchronises PLL lock and reset button, debounces the button,
// holds all domains for a power-on interval, then releases them in index order.
module rst_seq #(
  parameter int N_OUT           = 3,
  parameter int POR_CYCLES      = 1000000,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pll_lock,
  input  logic             i_but,
  input  logic             i_sw_rst,
  output logic [N_OUT-1:0] o_rst,
  output logic             o_busy,
  output logic [1:0]       o_cause
);

  localparam int MAX_SEQ = (POR_CYCLES > N_OUT * STAGE_GAP) ? POR_CYCLES : N_OUT * STAGE_GAP;
  localparam int MAX_CNT = (MAX_SEQ > DEBOUNCE_CYCLES) ? MAX_SEQ : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    POR_COUNT = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_LOCK = 2'd1,
    CAUSE_BUT  = 2'd2,
    CAUSE_SW   = 2'd3
  } cause_t;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [1:0]       r_lock_sync;
  logic [1:0]       r_but_sync;
  logic             w_lock;
  logic             w_but;
  logic             r_but_filt;
  logic             r_but_prev;
  logic [CW-1:0]    r_db_cnt;
  logic             w_but_rise;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [N_OUT-1:0] r_rst;
  logic [N_OUT-1:0] w_rst_nxt;
  cause_t           r_cause;
  cause_t           w_cause_nxt;

  // NOTE: assertion of the internal reset is asynchronous, release is delayed by
  // two edges so no flop sees i_rst_n rise close to its sampling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_sync <= '0;
    end else begin
      // NOTE: every clocked assignment uses <= so all flops update from pre-edge values.
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_lock_sync <= '0;
      r_but_sync  <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], i_pll_lock};
      r_but_sync  <= {r_but_sync[0], i_but};
    end
  end

  assign w_lock = r_lock_sync[1];
  assign w_but  = r_but_sync[1];

  // The filtered level flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_but_filt <= 1'b0;
      r_but_prev <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_but_prev <= r_but_filt;
      if (w_but != r_but_filt) begin
        if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_but_filt <= w_but;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + CW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_but_rise = r_but_filt & ~r_but_prev;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst;
    w_cause_nxt = r_cause;

    unique case (r_state)
      WAIT_LOCK: begin
        w_rst_nxt = '1;
        if (w_lock) begin
          w_state_nxt = POR_COUNT;
          w_cnt_nxt   = '0;
        end
      end
      POR_COUNT: begin
        w_rst_nxt = '1;
        if (r_but_filt) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(POR_CYCLES - 1)) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RELEASE: begin
        // Domain k is released once the stage counter reaches k*STAGE_GAP.
        for (int k = 0; k < N_OUT; k++) begin
          w_rst_nxt[k] = (int'(r_cnt) < k * STAGE_GAP);
        end
        if (r_cnt == CW'((N_OUT - 1) * STAGE_GAP)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RUN: begin
        w_rst_nxt = '0;
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_rst_nxt   = '1;
      end
    endcase

    // Restart requests override normal progress; lock loss wins over button over software.
    if (r_state != WAIT_LOCK) begin
      if (!w_lock) begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_rst_nxt   = '1;
        w_cause_nxt = CAUSE_LOCK;
      end else if (w_but_rise) begin
        w_state_nxt = POR_COUNT;
        w_cnt_nxt   = '0;
        w_rst_nxt   = '1;
        w_cause_nxt = CAUSE_BUT;
      end else if (i_sw_rst) begin
        w_state_nxt = POR_COUNT;
        w_cnt_nxt   = '0;
        w_rst_nxt   = '1;
        w_cause_nxt = CAUSE_SW;
      end
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_rst   <= '1;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst   <= w_rst_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  assign o_rst   = r_rst;
  assign o_busy  = (r_state != RUN);
  assign o_cause = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a timeline reference model pushes the expected
// outputs after every edge, and an independent monitor compares them at negedge.
module tb_rst_seq;

  localparam int N_OUT   = 3;
  localparam int POR     = 16;
  localparam int GAP     = 4;
  localparam int DB      = 8;
  localparam int REL0    = POR + 1;                 // timeline point where o_rst[0] drops
  localparam int SEQ_END = REL0 + (N_OUT - 1) * GAP; // timeline point of the last release

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_pll_lock;
  logic             i_but;
  logic             i_sw_rst;
  logic [N_OUT-1:0] o_rst;
  logic             o_busy;
  logic [1:0]       o_cause;

  rst_seq #(
    .N_OUT          (N_OUT),
    .POR_CYCLES     (POR),
    .STAGE_GAP      (GAP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_pll_lock(i_pll_lock),
    .i_but     (i_but),
    .i_sw_rst  (i_sw_rst),
    .o_rst     (o_rst),
    .o_busy    (o_busy),
    .o_cause   (o_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [N_OUT-1:0] rst;
    logic             busy;
    logic [1:0]       cause;
  } obs_t;

  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "reset";

  // Reference model: m_seq is the number of edges since the hold counter last
  // started from zero; every output is a threshold on that timeline.
  int m_live;
  bit m_lock_hist[$];
  bit m_but_hist[$];
  bit m_waiting;
  int m_seq;
  int m_cause;
  bit m_filt;
  bit m_prev;
  int m_run;

  task automatic model_reset();
    m_live      = 0;
    m_lock_hist = '{1'b0, 1'b0};
    m_but_hist  = '{1'b0, 1'b0};
    m_waiting   = 1'b1;
    m_seq       = 0;
    m_cause     = 0;
    m_filt      = 1'b0;
    m_prev      = 1'b0;
    m_run       = 0;
  endtask

  task automatic model_step();
    bit ls, bs, bf, rise;
    if (!i_rst_n) begin
      model_reset();
    end else if (m_live < 2) begin
      m_live++;
    end else begin
      ls   = m_lock_hist[0];
      bs   = m_but_hist[0];
      bf   = m_filt;
      rise = m_filt && !m_prev;
      void'(m_lock_hist.pop_front());
      m_lock_hist.push_back(i_pll_lock);
      void'(m_but_hist.pop_front());
      m_but_hist.push_back(i_but);
      m_prev = m_filt;
      if (bs != m_filt) begin
        m_run++;
        if (m_run == DB) begin
          m_filt = bs;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      if (m_waiting) begin
        if (ls) begin
          m_waiting = 1'b0;
          m_seq     = 0;
        end
      end else if (!ls) begin
        m_waiting = 1'b1;
        m_cause   = 1;
      end else if (rise) begin
        m_seq   = 0;
        m_cause = 2;
      end else if (i_sw_rst) begin
        m_seq   = 0;
        m_cause = 3;
      end else if (m_seq < POR) begin
        m_seq = bf ? 0 : m_seq + 1;
      end else if (m_seq < SEQ_END) begin
        m_seq++;
      end
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    for (int k = 0; k < N_OUT; k++) begin
      o.rst[k] = m_waiting || (m_seq < REL0 + k * GAP);
    end
    o.busy  = m_waiting || (m_seq < SEQ_END);
    o.cause = 2'(m_cause);
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got rst=%b busy=%b cause=%0d, expected rst=%b busy=%b cause=%0d",
               name, $time, act.rst, act.busy, act.cause, exp.rst, exp.busy, exp.cause);
    end
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = {o_rst, o_busy, o_cause};
        check(phase, a, e);
      end
    end
  end

  // Advance n edges; inputs change 1 time unit after each edge.
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      model_step();
      exp_q.push_back(model_out());
      #1;
    end
  endtask

  // Asynchronous reset: the expectation for the current cycle becomes the reset value.
  task automatic pull_reset(int cycles);
    i_rst_n = 1'b0;
    model_reset();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(model_out());
    tick(cycles);
    i_rst_n = 1'b1;
  endtask

  task automatic sw_pulse();
    i_sw_rst = 1'b1;
    tick(1);
    i_sw_rst = 1'b0;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_pll_lock = 1'b1;
    i_but      = 1'b0;
    i_sw_rst   = 1'b0;
    model_reset();
    tick(3);
    i_rst_n = 1'b1;

    phase = "power_on";
    tick(45);

    phase = "sw_rst";
    sw_pulse();
    tick(35);

    phase = "lock_loss";
    i_pll_lock = 1'b0;
    tick(6);
    i_pll_lock = 1'b1;
    tick(40);

    phase = "bounce";
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) i_but = ~i_but;
      tick(1);
    end
    i_but = 1'b0;
    tick(20);

    phase = "button";
    i_but = 1'b1;
    tick(8);
    i_but = 1'b0;
    tick(55);

    phase = "collision";
    i_pll_lock = 1'b0;
    tick(2);
    sw_pulse();
    tick(3);
    i_pll_lock = 1'b1;
    tick(40);

    phase = "async_rst";
    sw_pulse();
    tick(REL0 + 2);
    pull_reset(2);
    tick(45);

    phase = "random";
    repeat (40) begin
      case ($urandom_range(0, 5))
        0: tick($urandom_range(1, 30));
        1: begin
          sw_pulse();
          tick($urandom_range(1, 30));
        end
        2: begin
          i_pll_lock = 1'b0;
          tick($urandom_range(1, 5));
          i_pll_lock = 1'b1;
          tick($urandom_range(1, 30));
        end
        3: begin
          int per;
          per = $urandom_range(1, 4);
          for (int i = 0; i < int'($urandom_range(10, 40)); i++) begin
            if (i % per == 0) i_but = ~i_but;
            if ($urandom_range(0, 7) == 0) i_sw_rst = 1'b1;
            tick(1);
            i_sw_rst = 1'b0;
          end
          i_but = 1'b0;
          tick($urandom_range(1, 20));
        end
        4: begin
          i_but = 1'b1;
          tick($urandom_range(6, 14));
          i_but = 1'b0;
          tick($urandom_range(1, 40));
        end
        default: begin
          pull_reset($urandom_range(1, 3));
          tick($urandom_range(1, 30));
        end
      endcase
    end
    tick(40);

    repeat (2) @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_OUT, default 3: number of staged reset domains; legal range 1..8.
REQ-002 SHALL have parameter POR_CYCLES, default 1000000: cycles that all resets are held after lock and request are clear; legal range >= 1.
REQ-003 SHALL have parameter STAGE_GAP, default 16: cycles between successive domain releases; legal range >= 1.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 250000: cycles the synchronised button must be stable before its filtered level changes; legal range >= 1.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all flops sample on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_pll_lock, input, 1 bit: asynchronous PLL lock indication, high = locked.
REQ-008 SHALL have port i_but, input, 1 bit: asynchronous, bouncing reset button, high = pressed.
REQ-009 SHALL have port i_sw_rst, input, 1 bit: synchronous single-cycle software reset request from the SOC.
REQ-010 SHALL have port o_rst, output, N_OUT bits: active-high reset, one bit per domain; bit 0 releases first.
REQ-011 SHALL have port o_busy, output, 1 bit: high whenever the state is not RUN.
REQ-012 SHALL have port o_cause, output, 2 bits: cause of the last reset; 0 = external/power-on, 1 = lock loss, 2 = button, 3 = software.

Function
REQ-013 SHALL pass i_pll_lock and i_but each through a 2-flop synchroniser before any use.
REQ-014 SHALL change the filtered button level only after the synchronised button has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the debounce counter.
REQ-015 SHALL implement the states WAIT_LOCK, POR_COUNT, RELEASE and RUN.
REQ-016 In WAIT_LOCK, all o_rst bits SHALL be high, and the block SHALL enter POR_COUNT with the counter at 0 on the first edge where the synchronised lock is high.
REQ-017 In POR_COUNT, the counter SHALL increment each cycle and SHALL be held at 0 while the filtered button is high.
REQ-018 In POR_COUNT, the block SHALL enter RELEASE when the counter reaches POR_CYCLES-1.
REQ-019 On entry to RELEASE, o_rst[0] SHALL fall at the next edge, and o_rst[k] SHALL fall exactly k*STAGE_GAP cycles after o_rst[0].
REQ-020 The block SHALL enter RUN on the same edge that o_rst[N_OUT-1] falls; for N_OUT=1 this is the edge that o_rst[0] falls.
REQ-021 The counter width SHALL be ceil(log2(max(POR_CYCLES, N_OUT*STAGE_GAP, DEBOUNCE_CYCLES)+1)), and counters SHALL never wrap.
REQ-022 A synchronised lock low in any state other than WAIT_LOCK SHALL, at the next edge, set all o_rst bits high, enter WAIT_LOCK and set o_cause to 1.
REQ-023 A filtered-button rising edge in POR_COUNT, RELEASE or RUN SHALL, at the next edge, set all o_rst bits high, enter POR_COUNT with the counter at 0 and set o_cause to 2.
REQ-024 i_sw_rst high in POR_COUNT, RELEASE or RUN SHALL, at the next edge, set all o_rst bits high, enter POR_COUNT with the counter at 0 and set o_cause to 3.
REQ-025 i_sw_rst SHALL be ignored in WAIT_LOCK.
REQ-026 When restart events coincide, lock loss SHALL take priority over button, and button SHALL take priority over software; o_cause SHALL record the winner only.
REQ-027 A restart during RELEASE SHALL re-assert any already-released domains at once; no domain SHALL ever release out of index order.
REQ-028 o_rst SHALL be driven directly from flops, with no combinational path from any input to o_rst.

Reset
REQ-029 While i_rst_n is low, the block SHALL asynchronously force: o_rst = all ones, o_busy = 1, o_cause = 0, state = WAIT_LOCK, all counters and synchronisers = 0, filtered button = 0.
REQ-030 The deassertion of i_rst_n SHALL be synchronised: the block SHALL leave its reset values no earlier than the second rising edge after i_rst_n rises.
REQ-031 i_rst_n falling mid-operation SHALL assert all o_rst bits immediately, without waiting for a clock edge.

Verification (N_OUT=3, POR_CYCLES=16, STAGE_GAP=4, DEBOUNCE_CYCLES=8)
REQ-032 Power-on: with lock held high, release i_rst_n -> o_rst[0] falls 16+1 cycles after POR_COUNT entry, o_rst[1] 4 cycles later, o_rst[2] 8 cycles later; o_busy falls with o_rst[2]; o_cause = 0.
REQ-033 Lock loss: drop i_pll_lock in RUN -> o_rst = 3'b111 within 3 cycles and o_cause = 1; restore lock -> full sequence repeats.
REQ-034 Button bounce: toggle i_but every 3 cycles for 40 cycles -> no restart; hold i_but high for 8 cycles -> restart, o_cause = 2, and resets stay asserted until 16 cycles after the filtered release.
REQ-035 Software reset: pulse i_sw_rst for 1 cycle in RUN -> o_rst = 3'b111 at the next edge, o_cause = 3, release sequence identical to REQ-032.
REQ-036 Collision: i_sw_rst pulse coincident with the synchronised lock falling -> state WAIT_LOCK, o_cause = 1.
REQ-037 Async reset: pull i_rst_n low 2 cycles after o_rst[0] falls -> o_rst = 3'b111 before the next edge, o_cause = 0.
